me_frame_loader: RTL and testbench

- Front-end controller for the full-search motion estimation core; it is the writer side of the core's read-only SW/TB pixel memories.
- Accepts a byte stream of pixels and writes the template block (TB) memory, then the search window (SW) memory, through their write ports.
- Once both memories are loaded, it drives the core's req/ack handshake, captures min_sad/min_mvec and presents them as a held result.
- It also tells the top-level which side owns the memory address buses.

---
 rtl/me_frame_loader.sv | 164 ++++++++++++++++
 tb/tb_me_frame_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/me_frame_loader.sv
// Loads the TB memory, then the SW memory, from a byte stream, then runs one ME search and holds its result.
// Latency: each memory write lands 1 cycle after its accepted beat; the result is valid 1 cycle after me_ack falls.
// Backpressure: in_ready is high only while loading; in_valid in any other state is not a beat and is dropped.
module me_frame_loader #(
  parameter int TB_LENGTH    = 16,
  parameter int SW_LENGTH    = 64,
  parameter int PE_OUT_WIDTH = 8,
  localparam int ADDR_SW   = $clog2(SW_LENGTH * SW_LENGTH),
  localparam int ADDR_TB   = $clog2(TB_LENGTH * TB_LENGTH),
  localparam int CNT_WIDTH = $clog2((SW_LENGTH - TB_LENGTH + 1) * (SW_LENGTH - TB_LENGTH + 1)),
  localparam int SAD_WIDTH = $clog2(TB_LENGTH * TB_LENGTH) + PE_OUT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 wren_tb,
  output logic [ADDR_TB-1:0]   addr_tb,
  output logic [7:0]           data_tb,
  output logic                 wren_sw,
  output logic [ADDR_SW-1:0]   addr_sw,
  output logic [7:0]           data_sw,
  output logic                 mem_sel,
  output logic                 me_req,
  input  logic                 me_ack,
  input  logic [SAD_WIDTH-1:0] me_min_sad,
  input  logic [CNT_WIDTH-1:0] me_min_mvec,
  output logic [SAD_WIDTH-1:0] res_sad,
  output logic [CNT_WIDTH-1:0] res_mvec,
  output logic                 res_valid,
  output logic                 busy
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_TB,
    LOAD_SW,
    FLUSH,
    RUN,
    WAIT_LOW,
    DONE
  } state_t;

  // The SW memory is the deeper one, so one counter sized for it serves both loads.
  localparam logic [ADDR_SW-1:0] TB_LAST = ADDR_SW'(TB_LENGTH * TB_LENGTH - 1);
  localparam logic [ADDR_SW-1:0] SW_LAST = ADDR_SW'(SW_LENGTH * SW_LENGTH - 1);

  state_t             state_q;
  state_t             state_d;
  logic [ADDR_SW-1:0] beat_cnt;
  logic               beat;
  logic               last_beat;
  logic               job_start;
  logic               ack_capture;

  always_comb begin
    state_d     = state_q;
    in_ready    = 1'b0;
    mem_sel     = 1'b0;
    me_req      = 1'b0;
    busy        = 1'b1;
    res_valid   = 1'b0;
    job_start   = 1'b0;
    last_beat   = 1'b0;
    ack_capture = 1'b0;

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          job_start = 1'b1;
          state_d   = LOAD_TB;
        end
      end
      LOAD_TB: begin
        in_ready  = 1'b1;
        mem_sel   = 1'b1;
        last_beat = (beat_cnt == TB_LAST);
        if (in_valid && last_beat) state_d = LOAD_SW;
      end
      LOAD_SW: begin
        in_ready  = 1'b1;
        mem_sel   = 1'b1;
        last_beat = (beat_cnt == SW_LAST);
        if (in_valid && last_beat) state_d = FLUSH;
      end
      FLUSH: begin
        // The last SW write is still in flight, so the loader keeps the buses one more cycle.
        mem_sel = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        me_req = 1'b1;
        if (me_ack) begin
          ack_capture = 1'b1;
          state_d     = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!me_ack) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b0;
        res_valid = 1'b1;
        if (start) begin
          job_start = 1'b1;
          state_d   = LOAD_TB;
        end
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase

    beat = in_valid && in_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      beat_cnt <= '0;
      wren_tb  <= 1'b0;
      addr_tb  <= '0;
      data_tb  <= '0;
      wren_sw  <= 1'b0;
      addr_sw  <= '0;
      data_sw  <= '0;
      res_sad  <= '0;
      res_mvec <= '0;
    end else begin
      state_q <= state_d;

      wren_tb <= beat && (state_q == LOAD_TB);
      wren_sw <= beat && (state_q == LOAD_SW);

      if (beat && (state_q == LOAD_TB)) begin
        addr_tb <= beat_cnt[ADDR_TB-1:0];
        data_tb <= in_data;
      end

      if (beat && (state_q == LOAD_SW)) begin
        addr_sw <= beat_cnt;
        data_sw <= in_data;
      end

      // The counter restarts at each memory boundary so it never runs past a memory's depth.
      if (job_start) begin
        beat_cnt <= '0;
      end else if (beat) begin
        if (last_beat) beat_cnt <= '0;
        else           beat_cnt <= beat_cnt + 1'b1;
      end

      if (ack_capture) begin
        res_sad  <= me_min_sad;
        res_mvec <= me_min_mvec;
      end
    end
  end

endmodule

// File: tb/tb_me_frame_loader.sv
// Randomized bench for me_frame_loader: scoreboarded memory writes and results against a beat-level model plus a simple ME core model.
module tb_me_frame_loader;

  localparam int TBL     = 4;
  localparam int SWL     = 8;
  localparam int A_TB    = 4;
  localparam int A_SW    = 6;
  localparam int CNT_W   = 5;
  localparam int SAD_W   = 12;
  localparam int N_TB    = TBL * TBL;
  localparam int N_TOTAL = TBL * TBL + SWL * SWL;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic             wren_tb;
  logic [A_TB-1:0]  addr_tb;
  logic [7:0]       data_tb;
  logic             wren_sw;
  logic [A_SW-1:0]  addr_sw;
  logic [7:0]       data_sw;
  logic             mem_sel;
  logic             me_req;
  logic             me_ack;
  logic [SAD_W-1:0] me_min_sad;
  logic [CNT_W-1:0] me_min_mvec;
  logic [SAD_W-1:0] res_sad;
  logic [CNT_W-1:0] res_mvec;
  logic             res_valid;
  logic             busy;

  me_frame_loader #(.TB_LENGTH(TBL), .SW_LENGTH(SWL), .PE_OUT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wren_tb(wren_tb), .addr_tb(addr_tb), .data_tb(data_tb),
    .wren_sw(wren_sw), .addr_sw(addr_sw), .data_sw(data_sw), .mem_sel(mem_sel),
    .me_req(me_req), .me_ack(me_ack), .me_min_sad(me_min_sad), .me_min_mvec(me_min_mvec),
    .res_sad(res_sad), .res_mvec(res_mvec), .res_valid(res_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { bit sw; int addr; int data; } wr_t;
  typedef struct { int sad; int mvec; } res_t;

  wr_t  wr_q[$];
  res_t res_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   job_no   = 0;
  int   last_sad = 0;
  int   last_mvec = 0;
  logic prev_rv = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every memory write must match the oldest predicted beat; each new result must match the core's answer.
  always @(negedge clk) begin
    wr_t  e;
    res_t r;
    if (wren_tb === 1'b1 || wren_sw === 1'b1) begin
      chk("wr_both_ports", 32'(wren_tb & wren_sw), 0);
      if (wr_q.size() == 0) begin
        chk("wr_unexpected", 32'(wren_tb | wren_sw), 0);
      end else begin
        e = wr_q.pop_front();
        chk("wr_target_sw", 32'(wren_sw), 32'(e.sw));
        chk("wr_addr", wren_sw ? 32'(addr_sw) : 32'(addr_tb), e.addr);
        chk("wr_data", wren_sw ? 32'(data_sw) : 32'(data_tb), e.data);
      end
    end
    if (res_valid === 1'b1 && prev_rv !== 1'b1) begin
      if (res_q.size() == 0) begin
        chk("res_unexpected", 32'(res_valid), 0);
      end else begin
        r = res_q.pop_front();
        chk("res_sad", 32'(res_sad), r.sad);
        chk("res_mvec", 32'(res_mvec), r.mvec);
      end
    end
    prev_rv = res_valid;
  end

  // ME core model: ack 10 cycles after req, held until req falls, dropped 2 cycles later.
  initial begin
    me_ack = 1'b0;
    me_min_sad = '0;
    me_min_mvec = '0;
    forever begin
      @(negedge clk);
      if (me_req === 1'b1) begin
        repeat (10) @(posedge clk);
        #1;
        if (job_no == 0) begin
          me_min_sad = 12'h123; me_min_mvec = 5'd7;
        end else begin
          me_min_sad = 12'($urandom); me_min_mvec = 5'($urandom_range(0, 24));
        end
        last_sad = int'(me_min_sad);
        last_mvec = int'(me_min_mvec);
        res_q.push_back('{sad: last_sad, mvec: last_mvec});
        job_no++;
        me_ack = 1'b1;
        @(negedge clk);
        chk("req_at_ack", 32'(me_req), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("req_fall_after_ack", 32'(me_req), 0);
        me_min_sad = 12'($urandom);
        me_min_mvec = 5'($urandom);
        repeat (2) @(posedge clk);
        #1;
        me_ack = 1'b0;
        @(negedge clk);
        chk("res_valid_in_wait_low", 32'(res_valid), 0);
        @(negedge clk);
        chk("res_valid_after_ack_low", 32'(res_valid), 1);
      end
    end
  end

  // Drives a job: start pulse then nbeats pixel beats; beat k goes to TB[k] or SW[k-16] with data k.
  task automatic run_load(input int mode, input int nbeats, input bit start_mid);
    int beats = 0;
    int cyc = 0;
    bit v;
    in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    start = 1'b0;
    while (beats < nbeats && cyc < 1000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      in_valid = v;
      in_data  = v ? 8'(beats) : 8'($urandom);
      start    = start_mid && (beats == 40);
      @(negedge clk);
      if (cyc == 0) begin
        chk("res_valid_cleared", 32'(res_valid), 0);
        chk("busy_loading", 32'(busy), 1);
      end
      chk("in_ready_loading", 32'(in_ready), 1);
      chk("mem_sel_loading", 32'(mem_sel), 1);
      chk("me_req_loading", 32'(me_req), 0);
      if (v) begin
        if (beats < N_TB) wr_q.push_back('{sw: 1'b0, addr: beats, data: beats % 256});
        else              wr_q.push_back('{sw: 1'b1, addr: beats - N_TB, data: beats % 256});
        beats++;
      end
      cyc++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (nbeats == N_TOTAL) begin
      in_valid = 1'b1;
      in_data  = 8'hEE;
      @(negedge clk);
      chk("flush_in_ready", 32'(in_ready), 0);
      chk("flush_mem_sel", 32'(mem_sel), 1);
      chk("flush_me_req", 32'(me_req), 0);
      chk("flush_busy", 32'(busy), 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("run_me_req", 32'(me_req), 1);
      chk("run_mem_sel", 32'(mem_sel), 0);
      chk("run_in_ready", 32'(in_ready), 0);
      in_valid = 1'b0;
    end
  endtask

  // Called from the first RUN cycle; optionally pokes start mid-search, then waits for and inspects DONE.
  task automatic finish_job(input bit start_in_run);
    int t = 0;
    if (start_in_run) begin
      @(posedge clk); #1;
      start = 1'b1;
      @(negedge clk);
      chk("run_busy", 32'(busy), 1);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("run_req_after_start", 32'(me_req), 1);
    end
    while (res_valid !== 1'b1 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("res_valid_wait", 32'(res_valid), 1);
    repeat (3) begin
      @(negedge clk);
      chk("done_res_valid", 32'(res_valid), 1);
      chk("done_mem_sel", 32'(mem_sel), 0);
      chk("done_busy", 32'(busy), 0);
      chk("done_in_ready", 32'(in_ready), 0);
      chk("done_sad_held", 32'(res_sad), last_sad);
      chk("done_mvec_held", 32'(res_mvec), last_mvec);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_wren_tb", 32'(wren_tb), 0);
    chk("rst_wren_sw", 32'(wren_sw), 0);
    chk("rst_addr_tb", 32'(addr_tb), 0);
    chk("rst_addr_sw", 32'(addr_sw), 0);
    chk("rst_data_sw", 32'(data_sw), 0);
    chk("rst_mem_sel", 32'(mem_sel), 0);
    chk("rst_me_req", 32'(me_req), 0);
    chk("rst_res_sad", 32'(res_sad), 0);
    chk("rst_res_mvec", 32'(res_mvec), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    @(posedge clk); #1;

    run_load(0, N_TOTAL, 1'b0);
    finish_job(1'b0);
    run_load(1, N_TOTAL, 1'b1);
    finish_job(1'b1);
    run_load(2, N_TOTAL, 1'b0);
    finish_job(1'b0);

    run_load(0, 30, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h5A;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_in_ready", 32'(in_ready), 0);
      chk("post_rst_busy", 32'(busy), 0);
      chk("post_rst_wren_tb", 32'(wren_tb), 0);
      chk("post_rst_mem_sel", 32'(mem_sel), 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    run_load(2, N_TOTAL, 1'b0);
    finish_job(1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("writes_outstanding", 32'(wr_q.size()), 0);
    chk("results_outstanding", 32'(res_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
